// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM states and
// the rotate / priority-find / rotate-back search used to choose the next owner.
package rr_arbiter_8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req strictly after ptr, wrapping mod 8; ptr itself is searched last.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [IDX_W-1:0] ptr);
    pick_t            res;
    logic [3:0]       sh;
    logic [15:0]      dbl;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    sh  = {1'b0, ptr} + 4'd1;
    dbl = {req, req} >> sh;
    rot = dbl[N_REQ-1:0];
    off = '0;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        res.found = 1'b1;
        off       = IDX_W'(i);
      end
    end
    res.idx = ptr + IDX_W'(1) + off;
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_decoder.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
// Purely combinational, no backpressure.
module decoder_3_to_8 (
  input  logic [2:0] a,
  input  logic       enable,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    if (enable) y = 8'h01 << a;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a hold-time limit and preempt pulse.
// Grant appears one cycle after request; handoff is overlap-free and gap-free.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  // With MAX_HOLD=0 the counter simply saturates and never triggers a timeout.
  localparam bit         hold_en   = (MAX_HOLD != 0);
  localparam logic [7:0] hold_last = hold_en ? 8'(MAX_HOLD - 1) : 8'hFF;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             pre_q, pre_d;

  logic [N_REQ-1:0] others;
  pick_t            pick_idle;
  pick_t            pick_busy;

  assign others    = req & ~(N_REQ'(1) << idx_q);
  assign pick_idle = rr_pick(req, ptr_q);
  assign pick_busy = rr_pick(others, idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      idx_q   <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pre_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_idle.found) begin
          state_d = ARB_GRANT;
          idx_d   = pick_idle.idx;
          cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        if (!req[idx_q]) begin
          ptr_d = idx_q;
          cnt_d = '0;
          if (pick_busy.found) idx_d = pick_busy.idx;
          else                 state_d = ARB_IDLE;
        end else if (hold_en && cnt_q == hold_last && pick_busy.found) begin
          ptr_d = idx_q;
          idx_d = pick_busy.idx;
          cnt_d = '0;
          pre_d = 1'b1;
        end else if (cnt_q != hold_last) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt_valid = (state_q == ARB_GRANT);
    gnt_idx   = idx_q;
    preempt   = pre_q;
  end

  decoder_3_to_8 u_dec (
    .a      (idx_q),
    .enable (gnt_valid),
    .y      (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Four arbiters (MAX_HOLD 16, 4, 0, 1) share req/rst_n and are checked every
// cycle against an ownership model, plus directed literal checks.
module tb_rr_arbiter_8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      req;
  logic [3:0][7:0] gnt_w;
  logic [3:0][2:0] idx_w;
  logic [3:0]      vld_w;
  logic [3:0]      pre_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(16)) d0 (.clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_w[0]), .gnt_idx(idx_w[0]), .gnt_valid(vld_w[0]), .preempt(pre_w[0]));
  rr_arbiter_8 #(.MAX_HOLD(4)) d1 (.clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_w[1]), .gnt_idx(idx_w[1]), .gnt_valid(vld_w[1]), .preempt(pre_w[1]));
  rr_arbiter_8 #(.MAX_HOLD(0)) d2 (.clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_w[2]), .gnt_idx(idx_w[2]), .gnt_valid(vld_w[2]), .preempt(pre_w[2]));
  rr_arbiter_8 #(.MAX_HOLD(1)) d3 (.clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_w[3]), .gnt_idx(idx_w[3]), .gnt_valid(vld_w[3]), .preempt(pre_w[3]));

  // Model: owner (-1 = nobody), last owner, pointer, cycles held so far.
  int lim [4] = '{16, 4, 0, 1};
  int m_own [4];
  int m_last[4];
  int m_ptr [4];
  int m_held[4];
  bit m_pre [4];

  function automatic int pick(input logic [7:0] r, input int from);
    int j;
    for (int i = 1; i <= 8; i++) begin
      j = (from + i) % 8;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] oth;
    int         n;
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        m_own[k] = -1; m_last[k] = 0; m_ptr[k] = 7; m_held[k] = 0; m_pre[k] = 0;
      end else begin
        m_pre[k] = 0;
        if (m_own[k] < 0) begin
          n = pick(req, m_ptr[k]);
          if (n >= 0) begin m_own[k] = n; m_last[k] = n; m_held[k] = 1; end
        end else begin
          oth = req & ~(8'h01 << m_own[k]);
          if (!req[m_own[k]]) begin
            m_ptr[k] = m_own[k];
            n = pick(oth, m_own[k]);
            m_own[k] = n;
            if (n >= 0) begin m_last[k] = n; m_held[k] = 1; end
          end else if (lim[k] != 0 && m_held[k] >= lim[k] && oth != 0) begin
            m_ptr[k] = m_own[k];
            n = pick(oth, m_own[k]);
            m_own[k] = n; m_last[k] = n; m_held[k] = 1; m_pre[k] = 1;
          end else begin
            m_held[k]++;
          end
        end
      end
    end
  end

  task automatic check(input string name, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[d%0d] t=%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      check("model_gnt", k, int'(gnt_w[k]), (m_own[k] >= 0) ? (1 << m_own[k]) : 0);
      check("model_idx", k, int'(idx_w[k]), m_last[k]);
      check("model_vld", k, int'(vld_w[k]), (m_own[k] >= 0) ? 1 : 0);
      check("model_pre", k, int'(pre_w[k]), int'(m_pre[k]));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    tick(); tick();
    check("rst_gnt", 0, int'(gnt_w[0]), 'h00);
    check("rst_idx", 0, int'(idx_w[0]), 0);
    check("rst_vld", 0, int'(vld_w[0]), 0);
    check("rst_pre", 0, int'(pre_w[0]), 0);
    rst_n = 1'b1;
    tick();

    // Single request: granted one edge later.
    req = 8'h01;
    tick();
    check("first_gnt", 0, int'(gnt_w[0]), 'h01);
    check("first_vld", 0, int'(vld_w[0]), 1);
    check("first_pre", 0, int'(pre_w[0]), 0);

    // All requesting, MAX_HOLD=4: four cycles each, preempt at every switch.
    req = 8'h00; do_reset();
    req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      tick();
      check("rot4_idx", 1, int'(idx_w[1]), (c / 4) % 8);
      check("rot4_pre", 1, int'(pre_w[1]), (c > 0 && c % 4 == 0) ? 1 : 0);
    end

    // Release handoff 2 -> 5 with no gap.
    req = 8'h00; do_reset();
    req = 8'h04;
    tick();
    check("hand_gnt0", 0, int'(gnt_w[0]), 'h04);
    req = 8'h24;
    tick(); tick();
    check("hand_gnt1", 0, int'(gnt_w[0]), 'h04);
    req = 8'h20;
    tick();
    check("hand_gnt2", 0, int'(gnt_w[0]), 'h20);
    check("hand_pre", 0, int'(pre_w[0]), 0);

    // Lone requester saturates the counter, then loses at once to a newcomer.
    req = 8'h00; do_reset();
    req = 8'h08;
    repeat (300) tick();
    check("sat_gnt", 0, int'(gnt_w[0]), 'h08);
    check("sat_pre", 0, int'(pre_w[0]), 0);
    req = 8'h48;
    tick();
    check("sat_sw_gnt", 0, int'(gnt_w[0]), 'h40);
    check("sat_sw_pre", 0, int'(pre_w[0]), 1);
    tick();
    check("sat_pre_end", 0, int'(pre_w[0]), 0);

    // Asynchronous reset mid-grant.
    req = 8'h00; do_reset();
    req = 8'h10;
    repeat (3) tick();
    check("ar_gnt0", 0, int'(gnt_w[0]), 'h10);
    #2 rst_n = 1'b0;
    #1;
    check("ar_gnt", 0, int'(gnt_w[0]), 'h00);
    check("ar_vld", 0, int'(vld_w[0]), 0);
    check("ar_pre", 0, int'(pre_w[0]), 0);
    req = 8'h81;
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_win_idx", 0, int'(idx_w[0]), 0);
    check("ar_win_gnt", 0, int'(gnt_w[0]), 'h01);

    // Unlimited hold.
    req = 8'h00; do_reset();
    req = 8'h03;
    repeat (50) tick();
    check("inf_gnt", 2, int'(gnt_w[2]), 'h01);
    req = 8'h02;
    tick();
    check("inf_rel_gnt", 2, int'(gnt_w[2]), 'h02);

    // Random traffic, with held patterns so timeouts occur.
    req = 8'h00; do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      case ($urandom_range(0, 7))
        0:       req = 8'($urandom);
        1, 2:    req = 8'($urandom & $urandom);
        3:       req = req | 8'(1 << $urandom_range(0, 7));
        4:       req = req & ~8'(1 << $urandom_range(0, 7));
        default: req = req;
      endcase
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
